// File: rtl/instruction_fetch_mem.sv
// instruction_fetch_mem: byte-loadable instruction memory with a 1-cycle registered fetch port.
// Define IMEM_FAULT_EN to flag misaligned/out-of-range fetches instead of wrapping addresses.
module instruction_fetch_mem #(
  parameter int DEPTH_BYTES = 256,
  parameter int INST_BYTES = 4,
  parameter bit BIG_ENDIAN = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [31:0]             req_pc,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [8*INST_BYTES-1:0] rsp_inst,
  output logic                    rsp_fault,
  input  logic                    ld_en,
  input  logic [31:0]             ld_addr,
  input  logic [7:0]              ld_data,
  output logic [31:0]             fetch_cnt
);
  localparam int AW = DEPTH_BYTES > 1 ? $clog2(DEPTH_BYTES) : 1;
  localparam int W = 8 * INST_BYTES;
  typedef enum logic {EMPTY, FULL} state_t;
  state_t state, state_nx;
  logic [7:0] mem [DEPTH_BYTES] = '{default: 8'h00};
  logic accept, fault;
  logic [W-1:0] inst_raw;
  assign rsp_valid = state == FULL;
  assign req_ready = rst_n && !ld_en && (!rsp_valid || rsp_ready);
  assign accept = req_valid && req_ready;
  // Byte addresses wrap modulo the array size; with fault detection the wrapped data is discarded.
  always_comb begin
    inst_raw = '0;
    for (int i = 0; i < INST_BYTES; i++)
      inst_raw[8*(BIG_ENDIAN ? INST_BYTES-1-i : i) +: 8] = mem[AW'((req_pc + 32'(i)) % 32'(DEPTH_BYTES))];
  end
`ifdef IMEM_FAULT_EN
  assign fault = ((req_pc % 32'(INST_BYTES)) != 32'd0) || (({1'b0, req_pc} + 33'(INST_BYTES)) > 33'(DEPTH_BYTES));
`else
  assign fault = 1'b0;
`endif
  always_comb begin
    state_nx = accept ? FULL : (rsp_valid && rsp_ready) ? EMPTY : state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
      rsp_inst <= '0;
      rsp_fault <= 1'b0;
      fetch_cnt <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        rsp_inst <= fault ? '0 : inst_raw;
        rsp_fault <= fault;
        fetch_cnt <= fetch_cnt + 32'd1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (ld_en && ld_addr < 32'(DEPTH_BYTES)) mem[AW'(ld_addr)] <= ld_data;
  end
endmodule

// File: tb/tb_instruction_fetch_mem.sv
// tb_instruction_fetch_mem: scoreboard bench driving a big- and a little-endian instance in lockstep.
module tb_instruction_fetch_mem;
  localparam int DEPTH = 256;
`ifdef IMEM_FAULT_EN
  localparam bit FE = 1'b1;
`else
  localparam bit FE = 1'b0;
`endif
  logic clk = 0, rst_n = 1, req_valid = 0, rsp_ready = 0, ld_en = 0;
  logic [31:0] req_pc = 0, ld_addr = 0;
  logic [7:0] ld_data = 0;
  logic req_ready, rsp_valid, rsp_fault, le_ready, le_valid, le_fault;
  logic [31:0] rsp_inst, fetch_cnt, le_inst, le_cnt;
  typedef struct packed {logic [31:0] be; logic [31:0] le; logic f;} exp_t;
  exp_t sb[$];
  exp_t e;
  int compared = 0, mismatched = 0;
  logic [7:0] prog [12] = '{8'h34, 8'h08, 8'h00, 8'h0B, 8'h11, 8'h22, 8'h33, 8'h44,
                            8'hA0, 8'hB1, 8'hC2, 8'hD3};

  instruction_fetch_mem #(.DEPTH_BYTES(DEPTH), .INST_BYTES(4), .BIG_ENDIAN(1)) u_be (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_pc(req_pc),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_inst(rsp_inst), .rsp_fault(rsp_fault),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .fetch_cnt(fetch_cnt));
  instruction_fetch_mem #(.DEPTH_BYTES(DEPTH), .INST_BYTES(4), .BIG_ENDIAN(0)) u_le (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(le_ready), .req_pc(req_pc),
    .rsp_valid(le_valid), .rsp_ready(rsp_ready), .rsp_inst(le_inst), .rsp_fault(le_fault),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .fetch_cnt(le_cnt));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) chk("unexpected_rsp", 64'(sb.size()), 64'd1);
      else begin
        e = sb.pop_front();
        chk("rsp_inst_be", rsp_inst, e.be);
        chk("rsp_inst_le", le_inst, e.le);
        chk("rsp_fault", rsp_fault, e.f);
        chk("le_valid", le_valid, 1);
      end
    end
  end

  task automatic load(input logic [31:0] a, input logic [7:0] d);
    ld_en = 1; ld_addr = a; ld_data = d;
    @(posedge clk); #1 ld_en = 0;
  endtask

  task automatic fetch(input logic [31:0] pc, input logic [31:0] be, input logic [31:0] le, input logic f);
    int n = 0;
    req_valid = 1; req_pc = pc;
    @(negedge clk);
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    if (!req_ready) chk("accept", req_ready, 1);
    else sb.push_back({be, le, f});
    @(posedge clk); #1 req_valid = 0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || rsp_valid) && n < 50) begin @(negedge clk); n++; end
    chk("drain", 64'(sb.size()), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1);
  end

  initial begin
    #1 rst_n = 0;
    #1;
    chk("rst_valid", rsp_valid, 0);
    chk("rst_inst", rsp_inst, 0);
    chk("rst_fault", rsp_fault, 0);
    chk("rst_cnt", fetch_cnt, 0);
    chk("rst_ready", req_ready, 0);
    @(posedge clk); @(posedge clk); #1 rst_n = 1;
    for (int i = 0; i < 12; i++) load(i, prog[i]);
    load(254, 8'hEE);
    load(255, 8'hFF);
    rsp_ready = 1;
    fetch(0, 32'h3408000B, 32'h0B000834, 0);
    chk("latency_valid", rsp_valid, 1);
    chk("cnt_1", fetch_cnt, 1);
    drain();
    rsp_ready = 0;
    fork
      begin
        fetch(0, 32'h3408000B, 32'h0B000834, 0);
        fetch(4, 32'h11223344, 32'h44332211, 0);
        fetch(8, 32'hA0B1C2D3, 32'hD3C2B1A0, 0);
      end
      begin
        int n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
        for (int k = 0; k < 3; k++) begin
          chk("stall_valid", rsp_valid, 1);
          chk("stall_hold", rsp_inst, 32'h3408000B);
          chk("stall_ready", req_ready, 0);
          if (k < 2) @(negedge clk);
        end
        @(posedge clk); #1 rsp_ready = 1;
      end
    join
    drain();
    chk("cnt_4", fetch_cnt, 4);
    fetch(DEPTH - 2, FE ? 32'h0 : 32'hEEFF3408, FE ? 32'h0 : 32'h0834FFEE, FE);
    fetch(2, FE ? 32'h0 : 32'h000B1122, FE ? 32'h0 : 32'h22110B00, FE);
    drain();
    chk("cnt_6", fetch_cnt, 6);
    ld_en = 1; ld_addr = DEPTH; ld_data = 8'h99; req_valid = 1; req_pc = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("ld_block_ready", req_ready, 0);
      @(posedge clk); #1;
    end
    ld_en = 0;
    @(negedge clk);
    chk("ld_release_ready", req_ready, 1);
    if (req_ready) sb.push_back({32'h3408000B, 32'h0B000834, 1'b0});
    @(posedge clk); #1 req_valid = 0;
    drain();
    chk("cnt_7", fetch_cnt, 7);
    rsp_ready = 0;
    fetch(4, 32'h11223344, 32'h44332211, 0);
    chk("held_before_reset", rsp_valid, 1);
    #2 rst_n = 0;
    #1;
    chk("async_rst_valid", rsp_valid, 0);
    chk("async_rst_cnt", fetch_cnt, 0);
    chk("async_rst_inst", rsp_inst, 0);
    chk("async_rst_ready", req_ready, 0);
    sb.delete();
    rst_n = 1;
    rsp_ready = 1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("post_reset_idle", rsp_valid, 0);
    end
    @(posedge clk); #1;
    fetch(8, 32'hA0B1C2D3, 32'hD3C2B1A0, 0);
    drain();
    chk("cnt_after_reset", fetch_cnt, 1);
    chk("sb_empty", 64'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
